gps_pin_conditioner: RTL
========================

// Module: gps_pin_conditioner
// PURPOSE
//  Front end between the PmodGPS pins and the GPS fix state machine (gpsfixsm).
//  - Synchronises the asynchronous 1PPS and 3DF pins into clk_i.
//  - Converts each 1PPS rising edge into a single-cycle pulse.
//  - Debounces 3DF into a clean level.
//  - Measures the 1PPS period and flags whether the pulse train is within tolerance of 1 s.
// PARAMETERS
//  CLK_HZ          12_000_000  clk_i frequency; nominal 1PPS period in cycles
//  SYNC_STAGES     2           flops in each pin synchroniser, >=2
//  DEBOUNCE_CYCLES 1200        3DF must hold a new level this many consecutive cycles
//  PPS_TOL_CYCLES  12000       allowed |period - CLK_HZ| for a valid interval
//  PPS_MIN_HIGH    120         min synced-high cycles for a pulse (GPS_PPS_GLITCH_FILTER_EN only)
// PORTS
//  clk_i          in   1   system clock
//  reset_i        in   1   reset, asynchronous, active-low
//  pps_pin_i      in   1   raw 1PPS pin, asynchronous
//  threedf_pin_i  in   1   raw 3DF pin, asynchronous
//  onepps_o       out  1   one-cycle pulse per accepted 1PPS rising edge; drives gpsfixsm onepps_i
//  threedf_o      out  1   debounced 3DF level; drives gpsfixsm threedf_i
//  pps_valid_o    out  1   last 1PPS interval was within tolerance and no timeout has occurred
//  pps_period_o   out  PW  last measured interval in cycles; PW = $clog2(CLK_HZ+PPS_TOL_CYCLES+2)
// BEHAVIOUR
//  Reset
//   - While reset_i=0, all flops clear immediately: every output=0, state=IDLE, counters=0.
//   - Reset applies mid-operation with no exceptions.
//  Edge detect
//   - prev <= sync_out. onepps_o <= sync_out & ~prev (registered).
//   - onepps_o is high for exactly 1 cycle, starting at the (SYNC_STAGES+1)th clk_i rising edge after the pin rises.
//   - A pin held high produces one pulse only.
//  Period counter cnt
//   - On a onepps_o pulse: cnt <= 1. Otherwise, in ARMED or LOCKED: cnt <= cnt+1.
//   - Pulses P cycles apart therefore latch pps_period_o = P.
//  Timeout
//   - Limit is CLK_HZ+PPS_TOL_CYCLES+1.
//   - When cnt reaches the limit: state <= IDLE, pps_valid_o <= 0, cnt holds (no wrap).
//  State machine (in_tol = |cnt-CLK_HZ| <= PPS_TOL_CYCLES, evaluated on the pulse cycle)
//   - IDLE: pulse -> ARMED. pps_period_o is not updated.
//   - ARMED: pulse -> latch pps_period_o=cnt; in_tol ? LOCKED, pps_valid_o=1 : stay ARMED.
//   - LOCKED: pulse -> latch pps_period_o=cnt; !in_tol -> ARMED, pps_valid_o=0.
//   - ARMED/LOCKED: timeout -> IDLE.
//   - A pulse on the same cycle as the timeout: the pulse wins and is handled as a normal pulse.
//   - Tolerance boundaries are inclusive (CLK_HZ±PPS_TOL_CYCLES counts as valid).
//  3DF debounce
//   - dcnt counts cycles where sync_3df != threedf_o; dcnt resets to 0 whenever they are equal.
//   - When dcnt reaches DEBOUNCE_CYCLES: threedf_o <= sync_3df, dcnt <= 0.
//   - Total latency = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
// CONFIGURATION
//  GPS_PPS_GLITCH_FILTER_EN defined
//   - A rising edge starts a high-time counter.
//   - onepps_o pulses once, on the cycle the synced level has been high for PPS_MIN_HIGH consecutive cycles.
//   - If the level drops earlier: no pulse, the counter clears.
//   - Pulse latency grows by PPS_MIN_HIGH-1 cycles; the period measurement is unaffected for clean pulses.
//  GPS_PPS_GLITCH_FILTER_EN undefined
//   - Plain edge detect; PPS_MIN_HIGH is ignored.
// TESTING  (CLK_HZ=100, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PPS_TOL_CYCLES=5, PPS_MIN_HIGH=3)
//  1. Single pps_pin_i rise after reset -> onepps_o high 1 cycle at edge 3; pps_valid_o=0; pps_period_o=0.
//  2. Pin rises every 100 cycles x3 -> pps_period_o=100; pps_valid_o=1 from 2nd pulse onwards.
//  3. Locked, then intervals 95, 105, 106 -> valid stays 1, stays 1, drops to 0; pps_period_o=106.
//  4. Locked, no edge for 106 cycles -> pps_valid_o=0; the next pulse leaves pps_period_o unchanged.
//  5. threedf_pin_i 3-cycle high glitch -> threedf_o stays 0; held high -> threedf_o=1 six cycles after the rise.
//  6. Reset pulled low mid-lock -> all outputs 0 at once.
//     Macro on: 2-cycle pps glitch -> no pulse; 5-cycle pulse -> one pulse at edge 5.

Source files
------------

// File: rtl/gps_pin_conditioner.sv
// PmodGPS pin front end for gpsfixsm: pin synchronisers, 1PPS pulse generation, 3DF debounce, 1PPS period check.
// Define GPS_PPS_GLITCH_FILTER_EN to accept a 1PPS pulse only after PPS_MIN_HIGH consecutive synced-high cycles.
module gps_pin_conditioner #(
    parameter int CLK_HZ          = 12_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1200,
    parameter int PPS_TOL_CYCLES  = 12000,
    parameter int PPS_MIN_HIGH    = 120,
    localparam int PW             = $clog2(CLK_HZ + PPS_TOL_CYCLES + 2)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          pps_pin_i,
    input  logic          threedf_pin_i,
    output logic          onepps_o,
    output logic          threedf_o,
    output logic          pps_valid_o,
    output logic [PW-1:0] pps_period_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] CNT_LIMIT = PW'(CLK_HZ + PPS_TOL_CYCLES + 1);
    localparam logic [PW-1:0] TOL_LO    = PW'((CLK_HZ > PPS_TOL_CYCLES) ? (CLK_HZ - PPS_TOL_CYCLES) : 0);
    localparam logic [PW-1:0] TOL_HI    = PW'(CLK_HZ + PPS_TOL_CYCLES);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || PPS_MIN_HIGH < 1) begin : g_bad_params
        $error("gps_pin_conditioner: SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1, PPS_MIN_HIGH>=1 required");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } pps_state_t;

    logic [SYNC_STAGES-1:0] pps_sync;
    logic [SYNC_STAGES-1:0] df_sync;
    logic                   pps_synced;
    logic                   df_synced;
    logic [DW-1:0]          dcnt;
    logic [PW-1:0]          cnt;
    logic                   in_tol;
    pps_state_t             state;

    assign pps_synced = pps_sync[SYNC_STAGES-1];
    assign df_synced  = df_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pps_sync <= '0;
            df_sync  <= '0;
        end else begin
            pps_sync <= {pps_sync[SYNC_STAGES-2:0], pps_pin_i};
            df_sync  <= {df_sync[SYNC_STAGES-2:0], threedf_pin_i};
        end
    end

`ifdef GPS_PPS_GLITCH_FILTER_EN
    localparam int HW = $clog2(PPS_MIN_HIGH + 1);

    logic [HW-1:0] high_cnt;

    // high_cnt saturates at PPS_MIN_HIGH so a long pulse fires exactly once
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            high_cnt <= '0;
            onepps_o <= 1'b0;
        end else begin
            onepps_o <= pps_synced && (high_cnt == HW'(PPS_MIN_HIGH - 1));
            if (!pps_synced) begin
                high_cnt <= '0;
            end else if (high_cnt != HW'(PPS_MIN_HIGH)) begin
                high_cnt <= high_cnt + HW'(1);
            end
        end
    end
`else
    logic pps_prev;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pps_prev <= 1'b0;
            onepps_o <= 1'b0;
        end else begin
            pps_prev <= pps_synced;
            onepps_o <= pps_synced & ~pps_prev;
        end
    end
`endif

    // The cycle that completes DEBOUNCE_CYCLES mismatched cycles is the one that switches the output
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            dcnt      <= '0;
            threedf_o <= 1'b0;
        end else if (df_synced == threedf_o) begin
            dcnt <= '0;
        end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            dcnt      <= '0;
            threedf_o <= df_synced;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    assign in_tol = (cnt >= TOL_LO) && (cnt <= TOL_HI);

    // A pulse takes priority over the timeout, so an interval of exactly CNT_LIMIT is still measured
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            cnt          <= '0;
            pps_valid_o  <= 1'b0;
            pps_period_o <= '0;
        end else if (onepps_o) begin
            cnt <= PW'(1);
            if (state == IDLE) begin
                state <= ARMED;
            end else begin
                pps_period_o <= cnt;
                if (in_tol) begin
                    state       <= LOCKED;
                    pps_valid_o <= 1'b1;
                end else begin
                    state       <= ARMED;
                    pps_valid_o <= 1'b0;
                end
            end
        end else if (state != IDLE) begin
            if (cnt == CNT_LIMIT) begin
                state       <= IDLE;
                pps_valid_o <= 1'b0;
            end else begin
                cnt <= cnt + PW'(1);
            end
        end
    end

endmodule
